// File: rtl/coin_return_dispenser.sv
// Coin-return dispenser: accepts a refund amount, pays it out greedily in 1000/500/100 coins
// from on-hand inventory, and drives the hopper one coin at a time with a valid/ack handshake.
module coin_return_dispenser #(
  parameter int CNT_W       = 8,
  parameter int INV_INIT    = 10,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_refund_valid,
  input  logic [31:0]      i_refund_amount,
  output logic             o_refund_ready,
  output logic [2:0]       o_hopper_coin,
  output logic             o_hopper_valid,
  input  logic             i_hopper_ack,
  input  logic             i_restock_valid,
  input  logic [2:0]       i_restock_coin,
  output logic [CNT_W-1:0] o_inv_1000,
  output logic [CNT_W-1:0] o_inv_500,
  output logic [CNT_W-1:0] o_inv_100,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [31:0]      o_remainder
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_DONE, S_ERR} state_t;

  localparam int              TMR_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] INV_RST  = CNT_W'(INV_INIT);
  localparam logic [CNT_W-1:0] INV_MAX  = '1;

  function automatic logic [31:0] coin_value(input logic [2:0] coin);
    case (coin)
      3'b100:  return 32'd1000;
      3'b010:  return 32'd500;
      3'b001:  return 32'd100;
      default: return 32'd0;
    endcase
  endfunction

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_remaining, w_remaining_nxt;
  logic [31:0]      r_remainder, w_remainder_nxt;
  logic [2:0]       r_coin, w_coin_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [CNT_W-1:0] r_inv [3];   // index = coin bit: 0=100, 1=500, 2=1000
  logic [2:0]       w_pick;
  logic [2:0]       w_inc;
  logic [2:0]       w_dec;
  logic             w_ack;

  assign w_ack = (r_state == S_ISSUE) && i_hopper_ack;
  assign w_inc = (i_restock_valid && $onehot(i_restock_coin)) ? i_restock_coin : 3'b000;
  assign w_dec = w_ack ? r_coin : 3'b000;

  // Greedy choice from registered stock; later assignments override, so the largest coin wins.
  always_comb begin
    w_pick = 3'b000;
    if (r_remaining >= 32'd100  && r_inv[0] != '0) w_pick = 3'b001;
    if (r_remaining >= 32'd500  && r_inv[1] != '0) w_pick = 3'b010;
    if (r_remaining >= 32'd1000 && r_inv[2] != '0) w_pick = 3'b100;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_remainder_nxt = r_remainder;
    w_coin_nxt      = r_coin;
    w_timer_nxt     = r_timer;
    case (r_state)
      S_IDLE: begin
        if (i_refund_valid) begin
          w_remaining_nxt = i_refund_amount;
          w_state_nxt     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (r_remaining == 32'd0) begin
          w_state_nxt = S_DONE;
        end else if (w_pick == 3'b000) begin
          w_state_nxt = S_ERR;
        end else begin
          w_coin_nxt  = w_pick;
          w_timer_nxt = '0;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_hopper_ack) begin
          w_remaining_nxt = r_remaining - coin_value(r_coin);
          w_state_nxt     = S_SELECT;
        end else if (r_timer == TMO_LAST) begin
          w_state_nxt = S_ERR;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_DONE: begin
        w_remainder_nxt = 32'd0;
        w_state_nxt     = S_IDLE;
      end
      S_ERR: begin
        w_remainder_nxt = r_remaining;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_remainder <= '0;
      r_coin      <= '0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_remainder <= w_remainder_nxt;
      r_coin      <= w_coin_nxt;
      r_timer     <= w_timer_nxt;
    end
  end

  // A restock and an ack-decrement of the same coin cancel; increments saturate at full scale.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: r_inv is a three-entry register bank, not a RAM, so it takes the reset value directly.
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) r_inv[i] <= INV_RST;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_inc[i] && !w_dec[i] && r_inv[i] != INV_MAX) r_inv[i] <= r_inv[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i])                   r_inv[i] <= r_inv[i] - 1'b1;
      end
    end
  end

  assign o_refund_ready = (r_state == S_IDLE);
  assign o_busy         = (r_state != S_IDLE);
  assign o_hopper_valid = (r_state == S_ISSUE);
  assign o_hopper_coin  = (r_state == S_ISSUE) ? r_coin : 3'b000;
  assign o_done         = (r_state == S_DONE);
  assign o_error        = (r_state == S_ERR);
  assign o_remainder    = (r_state == S_DONE) ? 32'd0 :
                          (r_state == S_ERR)  ? r_remaining : r_remainder;
  assign o_inv_1000     = r_inv[2];
  assign o_inv_500      = r_inv[1];
  assign o_inv_100      = r_inv[0];

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Self-checking bench for coin_return_dispenser: a cycle-level behavioural model compared every
// cycle, plus directed refunds with hand-computed coin sequences and inventory counts.
module tb_coin_return_dispenser;

  localparam int CNT_W       = 8;
  localparam int INV_INIT    = 10;
  localparam int ACK_TIMEOUT = 16;
  localparam int INV_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             i_refund_valid = 1'b0;
  logic [31:0]      i_refund_amount = '0;
  logic             o_refund_ready;
  logic [2:0]       o_hopper_coin;
  logic             o_hopper_valid;
  logic             i_hopper_ack;
  logic             i_restock_valid;
  logic [2:0]       i_restock_coin;
  logic [CNT_W-1:0] o_inv_1000, o_inv_500, o_inv_100;
  logic             o_busy, o_done, o_error;
  logic [31:0]      o_remainder;

  always #5 clk = ~clk;

  coin_return_dispenser #(.CNT_W(CNT_W), .INV_INIT(INV_INIT), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_refund_valid(i_refund_valid), .i_refund_amount(i_refund_amount), .o_refund_ready(o_refund_ready),
    .o_hopper_coin(o_hopper_coin), .o_hopper_valid(o_hopper_valid), .i_hopper_ack(i_hopper_ack),
    .i_restock_valid(i_restock_valid), .i_restock_coin(i_restock_coin),
    .o_inv_1000(o_inv_1000), .o_inv_500(o_inv_500), .o_inv_100(o_inv_100),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_remainder(o_remainder)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hopper responder: 0 never acks, 1 acks in the cycle after valid rises,
  // 2 acks at random (also while idle), 3 like 1 but restocks a 100-coin with the ack.
  int   ack_mode = 1;
  int   valid_age = 0;
  logic r_ack = 1'b0;
  logic r_ack_restock = 1'b0;
  always @(negedge clk) begin
    if (o_hopper_valid) valid_age++; else valid_age = 0;
    case (ack_mode)
      0:       r_ack = 1'b0;
      1, 3:    r_ack = o_hopper_valid && valid_age >= 2;
      default: r_ack = ($urandom_range(0, 2) == 0);
    endcase
    r_ack_restock = (ack_mode == 3) && r_ack;
  end

  // Restock driver: 0 off, 1 constant coin every cycle, 2 random (including non-one-hot codes).
  int         rs_mode = 0;
  logic [2:0] rs_coin = '0;
  logic       s_rv = 1'b0;
  logic [2:0] s_rc = '0;
  always @(negedge clk) begin
    case (rs_mode)
      0:       s_rv = 1'b0;
      1:       begin s_rv = 1'b1; s_rc = rs_coin; end
      default: begin s_rv = ($urandom_range(0, 3) == 0); s_rc = 3'($urandom_range(0, 7)); end
    endcase
  end

  assign i_hopper_ack    = r_ack;
  assign i_restock_valid = s_rv | r_ack_restock;
  assign i_restock_coin  = r_ack_restock ? 3'b001 : s_rc;

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_PICK, M_PRESENT, M_DONE, M_ERR} mphase_e;
  mphase_e     m_phase;
  int unsigned m_rem, m_last, m_waited;
  int          m_coin;
  int unsigned m_inv [3];
  int unsigned m_nxt [3];
  int          m_pick;

  function automatic int unsigned value_of(input int c);
    return (c == 2) ? 1000 : (c == 1) ? 500 : 100;
  endfunction

  function automatic int greedy(input int unsigned rem, input int unsigned s0, input int unsigned s1,
                                input int unsigned s2);
    if (rem >= 1000 && s2 > 0) return 2;
    if (rem >= 500  && s1 > 0) return 1;
    if (rem >= 100  && s0 > 0) return 0;
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = M_IDLE; m_rem = 0; m_last = 0; m_waited = 0; m_coin = 0;
      for (int c = 0; c < 3; c++) m_inv[c] = INV_INIT;
    end else begin
      m_pick = greedy(m_rem, m_inv[0], m_inv[1], m_inv[2]);
      for (int c = 0; c < 3; c++) begin
        m_nxt[c] = m_inv[c];
        if (i_restock_valid && i_restock_coin == 3'(1 << c)) m_nxt[c]++;
        if (m_phase == M_PRESENT && i_hopper_ack && m_coin == c) m_nxt[c]--;
        if (m_nxt[c] > INV_MAX) m_nxt[c] = INV_MAX;
      end
      case (m_phase)
        M_IDLE:  if (i_refund_valid) begin m_rem = i_refund_amount; m_phase = M_PICK; end
        M_PICK: begin
          if (m_rem == 0)      m_phase = M_DONE;
          else if (m_pick < 0) m_phase = M_ERR;
          else begin m_coin = m_pick; m_waited = 0; m_phase = M_PRESENT; end
        end
        M_PRESENT: begin
          if (i_hopper_ack) begin
            m_rem   = m_rem - value_of(m_coin);
            m_phase = M_PICK;
          end else begin
            m_waited++;
            if (m_waited == ACK_TIMEOUT) m_phase = M_ERR;
          end
        end
        M_DONE:  begin m_last = 0;     m_phase = M_IDLE; end
        default: begin m_last = m_rem; m_phase = M_IDLE; end
      endcase
      m_inv = m_nxt;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("handshake",
          {o_refund_ready, o_busy, o_hopper_valid, o_hopper_coin, o_done, o_error},
          {m_phase == M_IDLE, m_phase != M_IDLE, m_phase == M_PRESENT,
           (m_phase == M_PRESENT) ? 3'(1 << m_coin) : 3'b000, m_phase == M_DONE, m_phase == M_ERR});
    check("remainder", o_remainder,
          (m_phase == M_DONE) ? 32'd0 : (m_phase == M_ERR) ? m_rem : m_last);
    check("inventory", {o_inv_1000, o_inv_500, o_inv_100},
          {CNT_W'(m_inv[2]), CNT_W'(m_inv[1]), CNT_W'(m_inv[0])});
  end

  // Records each coin as it is first presented to the hopper.
  logic [2:0] coins [$];
  logic       prev_valid = 1'b0;
  always @(negedge clk) begin
    if (o_hopper_valid && !prev_valid) coins.push_back(o_hopper_coin);
    prev_valid = o_hopper_valid;
  end

  function automatic logic [63:0] pack_coins();
    logic [63:0] v = '0;
    foreach (coins[i]) v = (v << 4) | 64'(coins[i]);
    return v;
  endfunction

  logic        got_done, got_err;
  logic [31:0] got_rem;
  int          valid_cycles;

  // Issue one refund (called at a negedge) and wait, bounded, for its done/error pulse.
  task automatic do_refund(input logic [31:0] amt, input int mode);
    bit acc = 1'b0;
    bit fin = 1'b0;
    ack_mode = mode;
    coins.delete();
    got_done = 1'b0; got_err = 1'b0; got_rem = '0; valid_cycles = 0;
    i_refund_valid  = 1'b1;
    i_refund_amount = amt;
    for (int n = 0; n < 200 && !acc; n++) begin
      acc = o_refund_ready;
      @(negedge clk);
    end
    i_refund_valid = 1'b0;
    check("accept", acc, 1);
    for (int n = 0; n < 3000 && !fin; n++) begin
      if (o_hopper_valid) valid_cycles++;
      if (o_done || o_error) begin
        fin = 1'b1; got_done = o_done; got_err = o_error; got_rem = o_remainder;
      end else begin
        @(negedge clk);
      end
    end
    check("finish", fin, 1);
    @(negedge clk);
  endtask

  initial begin
    int          nd;
    bit          seen;
    logic [31:0] amt;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {o_refund_ready, o_busy}, 2'b10);
    check("rst_hopper", {o_hopper_valid, o_hopper_coin, o_done, o_error}, 6'b0);
    check("rst_inv", {o_inv_1000, o_inv_500, o_inv_100}, {8'd10, 8'd10, 8'd10});
    check("rst_rem", o_remainder, 0);

    do_refund(32'd1800, 1);
    check("1800_coins", pack_coins(), 64'h42111);
    check("1800_flags", {got_done, got_err}, 2'b10);
    check("1800_rem", got_rem, 0);
    check("1800_inv", {o_inv_1000, o_inv_500, o_inv_100}, {8'd9, 8'd9, 8'd7});

    do_refund(32'd9000, 1);
    check("drain_coins", pack_coins(), 64'h444444444);
    check("drain_inv1000", o_inv_1000, 0);

    do_refund(32'd1000, 1);
    check("1000_coins", pack_coins(), 64'h22);
    check("1000_flags", {got_done, got_err}, 2'b10);
    check("1000_inv500", o_inv_500, 7);

    do_refund(32'd250, 1);
    check("250_coins", pack_coins(), 64'h11);
    check("250_flags", {got_done, got_err}, 2'b01);
    check("250_rem", got_rem, 50);
    check("250_inv100", o_inv_100, 5);

    do_refund(32'd500, 0);
    check("tmo_coins", pack_coins(), 64'h2);
    check("tmo_flags", {got_done, got_err}, 2'b01);
    check("tmo_rem", got_rem, 500);
    check("tmo_valid_cycles", valid_cycles, ACK_TIMEOUT);
    check("tmo_inv", {o_inv_1000, o_inv_500, o_inv_100}, {8'd0, 8'd7, 8'd5});

    do_refund(32'd0, 1);
    check("zero_coins", pack_coins(), 64'h0);
    check("zero_flags", {got_done, got_err}, 2'b10);
    check("zero_valid_cycles", valid_cycles, 0);

    do_refund(32'd100, 3);
    check("ack_restock_coins", pack_coins(), 64'h1);
    check("ack_restock_inv100", o_inv_100, 5);

    rs_coin = 3'b001; rs_mode = 1;
    repeat (260) @(negedge clk);
    rs_mode = 0;
    @(negedge clk);
    check("sat_inv100", o_inv_100, INV_MAX);

    rs_coin = 3'b011; rs_mode = 1;
    repeat (5) @(negedge clk);
    rs_mode = 0;
    repeat (2) @(negedge clk);
    check("bad_restock_inv", {o_inv_1000, o_inv_500, o_inv_100}, {8'd0, 8'd7, 8'd255});

    // Requester holds valid across two refunds; a busy DUT must not take the second early.
    coins.delete();
    ack_mode = 1; i_refund_amount = 32'd600; i_refund_valid = 1'b1; nd = 0;
    for (int n = 0; n < 200 && nd < 2; n++) begin
      @(negedge clk);
      if (o_done) nd++;
    end
    i_refund_valid = 1'b0;
    @(negedge clk);
    check("b2b_dones", nd, 2);
    check("b2b_coins", pack_coins(), 64'h2121);
    check("b2b_inv", {o_inv_1000, o_inv_500, o_inv_100}, {8'd0, 8'd5, 8'd253});

    // Reset in the middle of a coin presentation.
    ack_mode = 0; i_refund_amount = 32'd500; i_refund_valid = 1'b1;
    @(negedge clk);
    i_refund_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = o_hopper_valid;
    end
    check("mid_rst_presenting", seen, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {o_hopper_valid, o_hopper_coin, o_busy}, 5'b0);
    check("mid_rst_inv", {o_inv_1000, o_inv_500, o_inv_100}, {8'd10, 8'd10, 8'd10});
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_refund(32'd300, 1);
    check("post_rst_coins", pack_coins(), 64'h111);
    check("post_rst_flags", {got_done, got_err}, 2'b10);
    check("post_rst_inv100", o_inv_100, 7);

    // Randomized refunds, random acks and random restocks, all checked by the model.
    rs_mode = 2;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       amt = 32'($urandom_range(0, 30) * 100);
        1:       amt = 32'($urandom_range(0, 30) * 100 + 50);
        2:       amt = 32'($urandom_range(0, 5000));
        default: amt = 32'($urandom_range(0, 8) * 500);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_refund(amt, 2);
    end
    rs_mode = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
